// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and sizing helpers for the PLL lock sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_seq_state_t;
  localparam int RETRY_W = 4;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: PLL-side and status signals of the lock sequencer
interface pll_lock_sequencer_if;
  import pll_seq_pkg::*;
  logic               pll_lock_i;
  logic               restart_i;
  logic               pll_rst_o;
  logic               sys_resetn_o;
  logic               ready_o;
  logic               fault_o;
  logic [RETRY_W-1:0] retries_o;
  logic [2:0]         state_o;
  modport master (
    input  pll_lock_i, restart_i,
    output pll_rst_o, sys_resetn_o, ready_o, fault_o, retries_o, state_o
  );
  modport slave (
    output pll_lock_i, restart_i,
    input  pll_rst_o, sys_resetn_o, ready_o, fault_o, retries_o, state_o
  );
endinterface

// File: rtl/sync_ff.sv
// sync_ff: async-reset flop chain bringing an asynchronous level into the clk domain
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives PLL reset, waits for stable lock, retries on timeout, releases system reset
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int SYNC_STAGES   = 2
) (
  input logic                  clkin,
  input logic                  resetn,
  pll_lock_sequencer_if.master pll
);
  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RMAX = RETRY_W'(MAX_RETRIES);
  pll_seq_state_t     state, nxt;
  logic [CW-1:0]      cnt, cnt_nxt, cnt_inc;
  logic [RETRY_W-1:0] ret_nxt;
  logic               lock_s;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clkin),
    .rst_n(resetn),
    .d    (pll.pll_lock_i),
    .q    (lock_s)
  );
  // counter saturates so a stalled state can never alias back to zero
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt_inc;
    ret_nxt = pll.retries_o;
    if (pll.restart_i) begin
      nxt     = RESET_PLL;
      cnt_nxt = '0;
      ret_nxt = '0;
    end else
      case (state)
        RESET_PLL:
          if (cnt == RST_LAST) begin
            nxt     = WAIT_LOCK;
            cnt_nxt = '0;
          end
        WAIT_LOCK:
          if (lock_s) begin
            nxt     = STABLE;
            cnt_nxt = '0;
          end else if (cnt == TMO_LAST) begin
            nxt     = (pll.retries_o == RMAX) ? FAULT : RESET_PLL;
            cnt_nxt = '0;
            ret_nxt = (pll.retries_o == RMAX) ? pll.retries_o : pll.retries_o + 1'b1;
          end
        STABLE:
          if (!lock_s) begin
            nxt     = WAIT_LOCK;
            cnt_nxt = '0;
          end else if (cnt == STB_LAST) begin
            nxt     = RUN;
            cnt_nxt = '0;
            ret_nxt = '0;
          end
        RUN:
          if (!lock_s) begin
            nxt     = RESET_PLL;
            cnt_nxt = '0;
          end
        FAULT: cnt_nxt = '0;
        default: begin
          nxt     = RESET_PLL;
          cnt_nxt = '0;
        end
      endcase
  end
  // outputs are decoded from the next state so they change on the same edge as state
  always_ff @(posedge clkin or negedge resetn)
    if (!resetn) begin
      state            <= RESET_PLL;
      cnt              <= '0;
      pll.pll_rst_o    <= 1'b1;
      pll.sys_resetn_o <= 1'b0;
      pll.ready_o      <= 1'b0;
      pll.fault_o      <= 1'b0;
      pll.retries_o    <= '0;
    end else begin
      state            <= nxt;
      cnt              <= cnt_nxt;
      pll.pll_rst_o    <= (nxt == RESET_PLL) || (nxt == FAULT);
      pll.sys_resetn_o <= nxt == RUN;
      pll.ready_o      <= nxt == RUN;
      pll.fault_o      <= nxt == FAULT;
      pll.retries_o    <= ret_nxt;
    end
  assign pll.state_o = state;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios plus random lock/restart/reset traffic against a behavioural model
module tb_pll_lock_sequencer;
  localparam int RC = 4, LT = 32, SC = 8, MR = 2, SS = 2;
  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_FLT = 4;
  logic clkin = 1'b0;
  logic resetn = 1'b1;
  bit   run_chk = 1'b0;
  int   n_cmp = 0, n_err = 0;
  pll_lock_sequencer_if bus ();
  pll_lock_sequencer #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR),
    .SYNC_STAGES  (SS)
  ) dut (
    .clkin (clkin),
    .resetn(resetn),
    .pll   (bus)
  );
  always #5 clkin = ~clkin;
  task automatic chk(input string n, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // model: phase plus cycles spent in it; lock_s is the input recorded SS edges earlier
  int m_ph = P_RST, m_t = 0, m_ret = 0, m_n = 0;
  bit hist [0:65535];
  wire m_ls = (m_n >= SS) ? hist[m_n-SS] : 1'b0;
  always @(posedge clkin or negedge resetn)
    if (!resetn) begin
      m_ph <= P_RST; m_t <= 0; m_ret <= 0; m_n <= 0;
    end else begin
      m_n <= m_n + 1;
      hist[m_n] <= bus.pll_lock_i;
      if (bus.restart_i) begin
        m_ph <= P_RST; m_t <= 0; m_ret <= 0;
      end else if (m_ph == P_RST) begin
        if (m_t + 1 == RC) begin m_ph <= P_WAIT; m_t <= 0; end
        else m_t <= m_t + 1;
      end else if (m_ph == P_WAIT) begin
        if (m_ls) begin m_ph <= P_STB; m_t <= 0; end
        else if (m_t + 1 == LT) begin
          m_t <= 0;
          if (m_ret == MR) m_ph <= P_FLT;
          else begin m_ph <= P_RST; m_ret <= m_ret + 1; end
        end else m_t <= m_t + 1;
      end else if (m_ph == P_STB) begin
        if (!m_ls) begin m_ph <= P_WAIT; m_t <= 0; end
        else if (m_t + 1 == SC) begin m_ph <= P_RUN; m_ret <= 0; m_t <= 0; end
        else m_t <= m_t + 1;
      end else if (m_ph == P_RUN) begin
        if (!m_ls) begin m_ph <= P_RST; m_t <= 0; end
      end
    end
  always @(negedge clkin)
    if (run_chk) begin
      chk("pll_rst", int'(bus.pll_rst_o), int'(m_ph == P_RST || m_ph == P_FLT));
      chk("sys_resetn", int'(bus.sys_resetn_o), int'(m_ph == P_RUN));
      chk("ready", int'(bus.ready_o), int'(m_ph == P_RUN));
      chk("fault", int'(bus.fault_o), int'(m_ph == P_FLT));
      chk("retries", int'(bus.retries_o), m_ret);
      chk("state", int'(bus.state_o), m_ph);
    end
  always @(posedge bus.sys_resetn_o) chk("sysrst_rise_in_reset", int'(resetn), 1);
  function automatic logic sig(input int w);
    case (w)
      0: return bus.ready_o;
      1: return bus.sys_resetn_o;
      default: return bus.state_o == 3'd2;
    endcase
  endfunction
  task automatic wait_sig(input int w, input logic v, input int lim, output int k);
    k = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clkin);
      if (sig(w) == v) begin k = i; break; end
    end
  endtask
  task automatic chk_reset_vals(input string n);
    chk({n, "_pll_rst"}, int'(bus.pll_rst_o), 1);
    chk({n, "_sys_resetn"}, int'(bus.sys_resetn_o), 0);
    chk({n, "_ready"}, int'(bus.ready_o), 0);
    chk({n, "_fault"}, int'(bus.fault_o), 0);
    chk({n, "_retries"}, int'(bus.retries_o), 0);
    chk({n, "_state"}, int'(bus.state_o), 0);
  endtask
  task automatic arst();
    @(posedge clkin);
    #2 resetn = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge clkin);
    @(negedge clkin);
    resetn = 1'b1;
  endtask
  task automatic pulse_width(output int w);
    w = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.pll_rst_o) break;
      w++;
      @(negedge clkin);
    end
  endtask
  logic s_rst [200];
  logic s_flt [200];
  int   s_ret [200];
  int   runs [16];
  int   exp_runs [7] = '{4, 32, 4, 32, 4, 32, 92};
  initial begin
    int k, w, hi, nr, cur, ff;
    bus.pll_lock_i = 1'b0;
    bus.restart_i  = 1'b0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clkin);
    chk_reset_vals("reset");
    run_chk = 1'b1;
    // 1: power-up, lock 10 cycles after release
    resetn = 1'b1;
    #1 hi = int'(bus.pll_rst_o);
    repeat (9) begin @(negedge clkin); hi += int'(bus.pll_rst_o); end
    chk("t1_rst_width", hi, RC);
    @(negedge clkin);
    bus.pll_lock_i = 1'b1;
    wait_sig(0, 1'b1, 60, k);
    chk("t1_ready_latency", k, SS + SC + 1);
    chk("t1_sys_resetn", int'(bus.sys_resetn_o), 1);
    chk("t1_retries", int'(bus.retries_o), 0);
    // 4: lock loss in RUN
    @(negedge clkin);
    bus.pll_lock_i = 1'b0;
    wait_sig(1, 1'b0, 20, k);
    chk("t4_drop_latency", k, 3);
    pulse_width(w);
    chk("t4_rst_width", w, RC);
    // 2: relock with a one-cycle glitch at the 5th STABLE cycle
    bus.pll_lock_i = 1'b1;
    hi = 0;
    repeat (5) begin @(negedge clkin); hi += int'(bus.ready_o); end
    bus.pll_lock_i = 1'b0;
    @(negedge clkin);
    hi += int'(bus.ready_o);
    bus.pll_lock_i = 1'b1;
    chk("t2_no_early_ready", hi, 0);
    wait_sig(0, 1'b1, 60, k);
    chk("t2_ready_latency", k, 11);
    chk("t2_retries", int'(bus.retries_o), 0);
    // 3: lock never arrives
    bus.pll_lock_i = 1'b0;
    resetn = 1'b0;
    @(negedge clkin);
    resetn = 1'b1;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clkin);
      s_rst[i] = bus.pll_rst_o;
      s_flt[i] = bus.fault_o;
      s_ret[i] = int'(bus.retries_o);
    end
    nr = 0; cur = 1;
    for (int i = 1; i < 200; i++)
      if (s_rst[i] == s_rst[i-1]) cur++;
      else begin
        if (nr < 16) runs[nr] = cur;
        nr++;
        cur = 1;
      end
    if (nr < 16) runs[nr] = cur;
    nr++;
    chk("t3_start_high", int'(s_rst[0]), 1);
    chk("t3_run_count", nr, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("t3_run%0d", i), (i < nr) ? runs[i] : -1, exp_runs[i]);
    ff = -1;
    for (int i = 199; i >= 0; i--) if (s_flt[i]) ff = i;
    chk("t3_fault_start", ff, 108);
    chk("t3_retries_mid", s_ret[40], 1);
    chk("t3_retries_end", s_ret[199], MR);
    // 5: restart out of FAULT
    @(negedge clkin);
    bus.restart_i = 1'b1;
    @(negedge clkin);
    bus.restart_i = 1'b0;
    chk("t5_fault", int'(bus.fault_o), 0);
    chk("t5_retries", int'(bus.retries_o), 0);
    pulse_width(w);
    chk("t5_rst_width", w, RC);
    bus.pll_lock_i = 1'b1;
    wait_sig(0, 1'b1, 60, k);
    chk("t5_ready_latency", k, 11);
    // 6: async reset in RUN, then in STABLE
    arst();
    wait_sig(2, 1'b1, 40, k);
    chk("t6_reach_stable", int'(k > 0), 1);
    arst();
    wait_sig(0, 1'b1, 60, k);
    chk("t6_relock", int'(k > 0), 1);
    // random traffic
    repeat (200) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        bus.restart_i = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clkin);
        bus.restart_i = 1'b0;
      end else if (r < 9) arst();
      else if (r < 14) begin
        bus.pll_lock_i = 1'b0;
        repeat (120) @(negedge clkin);
      end else begin
        bus.pll_lock_i = ($urandom_range(0, 2) != 0);
        repeat ($urandom_range(1, 40)) @(negedge clkin);
      end
    end
    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
